maint_log_ctrl: RTL and testbench
=================================

Name: maint_log_ctrl

Overview:
Controller and arbiter for the elevator maintenance-log block RAM (2048 x 8, single port, synchronous read).
- Shares the RAM write port between NUM_SRC event sources (door, motor, floor-sensor and fault monitors) using round-robin arbitration.
- Keeps the log as a circular buffer.
- Sequences a non-destructive oldest-to-newest dump to the service/technician interface.
- Sits between the event monitors and the RAM instance. It is the only master of the RAM port.

Parameters:
NUM_SRC, 4, number of event-source requesters
ADDR_W, 11, RAM address width; log depth = 2**ADDR_W
DATA_W, 8, log entry width
WRAP, 1, 1 = overwrite oldest entry when full; 0 = drop new entries when full

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
src_req  in  NUM_SRC  per-source write request; held high until acked
src_data  in  NUM_SRC*DATA_W  per-source entry; source i at bits [i*DATA_W +: DATA_W]
src_ack  out  NUM_SRC  one-hot, one-cycle pulse; entry consumed this cycle
dump_start  in  1  pulse: begin log dump
dump_valid  out  1  dump_data valid this cycle
dump_data  out  DATA_W  dumped entry (= ram_do)
dump_done  out  1  one-cycle pulse after the last dumped entry
busy  out  1  high while a dump is in progress (states DUMP, DRAIN, DONE)
log_count  out  ADDR_W+1  number of valid entries, 0..2**ADDR_W
log_full  out  1  log_count == 2**ADDR_W
overflow  out  1  sticky: an entry was overwritten (WRAP=1) or dropped (WRAP=0)
ram_addr  out  ADDR_W  RAM address
ram_di  out  DATA_W  RAM write data
ram_we  out  1  RAM write enable
ram_en  out  1  RAM enable; high only on an access cycle
ram_do  in  DATA_W  RAM read data, valid the cycle after the read address

Behaviour:
- Reset (async) forces every output to 0: src_ack, ram_*, dump_*, busy, log_count, log_full, overflow. It also clears wr_ptr, rr pointer and state = IDLE.
  - Applies mid-dump too: the dump is abandoned with no dump_done pulse.
- States: IDLE, DUMP, DRAIN, DONE.
- IDLE:
  - If dump_start = 1: go to DUMP. Load rd_ptr = (wr_ptr - log_count) mod 2**ADDR_W and remaining = log_count. No write is granted that cycle (dump has priority).
  - If dump_start = 1 and log_count == 0: go to DONE directly.
  - Otherwise, if any src_req is set: grant one source by round-robin.
    - Drive ram_en=1, ram_we=1, ram_addr=wr_ptr, ram_di=that source's data, and set src_ack[i]=1 in the same cycle (combinational from registered state).
    - At the clock edge, increment wr_ptr (wraps 2047->0).
- Round-robin: priority pointer resets to source 0. After granting i, highest priority becomes (i+1) mod NUM_SRC.
  - Under continuous requests, at most one grant per cycle, with no starvation.
- Full log, WRAP=1: the write proceeds and overwrites the oldest entry. log_count stays at max and overflow is set.
- Full log, WRAP=0: src_ack still pulses (the source is never deadlocked). ram_we=0, ram_en=0, wr_ptr unchanged, overflow set.
- Not full: log_count increments on each write.
- DUMP:
  - Each cycle: ram_en=1, ram_we=0, ram_addr=rd_ptr; then rd_ptr++ (wrap) and remaining--.
  - When remaining==1 at the issue edge, go to DRAIN.
  - src_req is not acked during DUMP, DRAIN or DONE; writes stall.
- Read pipeline: dump_valid is registered, high the cycle after each read issue, with dump_data=ram_do. Entries appear oldest first, one per cycle, with no gaps.
- DRAIN: the last dump_valid occurs; go to DONE.
- DONE: dump_done=1 for one cycle; return to IDLE.
  - Empty dump timing: dump_done pulses the cycle after dump_start, with no dump_valid.
- dump_start outside IDLE is ignored.
- The dump does not modify log_count or wr_ptr.
- overflow clears only on reset.

Decomposition:
- Shared package maint_log_pkg:
  - state encoding constants: IDLE=2'd0, DUMP=2'd1, DRAIN=2'd2, DONE=2'd3
  - default widths: LOG_ADDR_W=11, LOG_DATA_W=8
  - LOG_DEPTH = 2**LOG_ADDR_W
- One sub-module: maint_rr_arbiter. Inputs: NUM_SRC request vector and an advance strobe. Outputs: one-hot grant and encoded index; it holds the rotating priority pointer.
- The RAM itself stays outside this block.

Test Plan:
1. Reset, then src_req[1]=1 with data 0xA5 -> same cycle src_ack[1]=1, ram_we=1, ram_addr=0, ram_di=0xA5; next cycle log_count=1.
2. All four src_req held high -> src_ack grants in cycles 1..5 go to sources 0,1,2,3,0; ram_addr goes 0,1,2,3,4.
3. Write 0x11, 0x22, 0x33, then pulse dump_start -> dump_valid high on 3 consecutive cycles with 0x11, 0x22, 0x33; dump_done pulses the following cycle; log_count stays 3; a src_req held during the dump is acked only after return to IDLE.
4. WRAP=1: write 2048 entries (value = addr[7:0]), then write 0xEE -> ram_addr=0 written, log_count=2048, log_full=1, overflow=1; a following dump gives first data 0x01 and last data 0xEE after 2048 valid cycles.
5. WRAP=0 and full: src_req[2] with data 0x5A -> src_ack[2]=1, ram_we=0, overflow=1, log_count stays 2048; a dump shows no 0x5A.
6. dump_start with log_count=0 -> dump_done the next cycle, no dump_valid. Separately, assert reset mid-dump -> all outputs 0 immediately, no dump_done, log_count=0 after release.

Source files
------------

// File: rtl/maint_log_pkg.sv
`default_nettype none
// =====================================================================
// maint_log_pkg : shared widths, depth and FSM encoding for the
//                 maintenance-log controller.   Rev 1.0
// =====================================================================
package maint_log_pkg;

    localparam int LOG_ADDR_W = 11;
    localparam int LOG_DATA_W = 8;
    localparam int LOG_DEPTH  = 2**LOG_ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DUMP  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } log_state_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/maint_log_ctrl_if.sv
`default_nettype none
// =====================================================================
// maint_log_ctrl_if : event-source, dump, status and RAM-port bundle.
//                     Rev 1.0
// =====================================================================
interface maint_log_ctrl_if
    import maint_log_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int ADDR_W  = LOG_ADDR_W,
    parameter int DATA_W  = LOG_DATA_W
);
    logic [NUM_SRC-1:0]        src_req;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC-1:0]        src_ack;
    logic                      dump_start;
    logic                      dump_valid;
    logic [DATA_W-1:0]         dump_data;
    logic                      dump_done;
    logic                      busy;
    logic [ADDR_W:0]           log_count;
    logic                      log_full;
    logic                      overflow;
    logic [ADDR_W-1:0]         ram_addr;
    logic [DATA_W-1:0]         ram_di;
    logic                      ram_we;
    logic                      ram_en;
    logic [DATA_W-1:0]         ram_do;

    modport master (
        input  src_req, src_data, dump_start, ram_do,
        output src_ack, dump_valid, dump_data, dump_done, busy,
               log_count, log_full, overflow,
               ram_addr, ram_di, ram_we, ram_en
    );

    modport slave (
        output src_req, src_data, dump_start, ram_do,
        input  src_ack, dump_valid, dump_data, dump_done, busy,
               log_count, log_full, overflow,
               ram_addr, ram_di, ram_we, ram_en
    );

endinterface
`default_nettype wire

// File: rtl/maint_rr_arbiter.sv
`default_nettype none
// =====================================================================
// maint_rr_arbiter : round-robin requester arbiter with rotating
//                    priority pointer.   Rev 1.0
// =====================================================================
module maint_rr_arbiter
    import maint_log_pkg::*;
#(
    parameter  int NUM_SRC = 4,
    localparam int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] req,
    input  logic               advance,
    output logic [NUM_SRC-1:0] grant,
    output logic [IDX_W-1:0]   index,
    output logic               any
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    // Scan starting at the priority pointer; first requester wins.
    always_comb begin
        grant   = '0;
        index   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_cand = IDX_W'((int'(r_ptr) + k) % NUM_SRC);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                index   = w_cand;
            end
        end
        grant[index] = w_found;
    end

    assign any = |req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= IDX_W'(rr_next(int'(index), NUM_SRC));
        end
    end

endmodule
`default_nettype wire

// File: rtl/maint_log_ctrl.sv
`default_nettype none
// =====================================================================
// maint_log_ctrl : maintenance-log RAM arbiter, circular log keeper
//                  and oldest-first dump sequencer.   Rev 1.0
// =====================================================================
module maint_log_ctrl
    import maint_log_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int ADDR_W  = LOG_ADDR_W,
    parameter int DATA_W  = LOG_DATA_W,
    parameter bit WRAP    = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    maint_log_ctrl_if.master bus
);

    localparam int              IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [ADDR_W:0] C_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    log_state_t          r_state;
    log_state_t          w_state_nxt;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W:0]     r_remaining;
    logic                r_overflow;
    logic                r_dump_valid;
    logic [NUM_SRC-1:0]  w_grant;
    logic [IDX_W-1:0]    w_index;
    logic                w_any;
    logic                w_idle;
    logic                w_start;
    logic                w_take;
    logic                w_write;
    logic                w_read;
    logic                w_full;
    logic [DATA_W-1:0]   w_src_data [NUM_SRC];

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign w_src_data[gi] = bus.src_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    maint_rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (bus.src_req),
        .advance (w_take),
        .grant   (w_grant),
        .index   (w_index),
        .any     (w_any)
    );

    // A dump request in IDLE pre-empts any write in the same cycle.
    assign w_idle  = (r_state == IDLE);
    assign w_start = w_idle && bus.dump_start && !reset;
    assign w_take  = w_idle && !bus.dump_start && w_any && !reset;
    assign w_full  = (r_count == C_DEPTH);
    assign w_write = w_take && (WRAP || !w_full);
    assign w_read  = (r_state == DUMP);

    always_comb begin
        w_state_nxt  = r_state;
        bus.src_ack  = '0;
        bus.ram_en   = 1'b0;
        bus.ram_we   = 1'b0;
        bus.ram_addr = '0;
        bus.ram_di   = '0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = (r_count == '0) ? DONE : DUMP;
                end
                if (w_take) begin
                    bus.src_ack = w_grant;
                end
                if (w_write) begin
                    bus.ram_en   = 1'b1;
                    bus.ram_we   = 1'b1;
                    bus.ram_addr = r_wr_ptr;
                    bus.ram_di   = w_src_data[w_index];
                end
            end
            DUMP: begin
                bus.ram_en   = 1'b1;
                bus.ram_addr = r_rd_ptr;
                if (r_remaining == (ADDR_W+1)'(1)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN:   w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_remaining  <= '0;
            r_overflow   <= 1'b0;
            r_dump_valid <= 1'b0;
        end else begin
            r_dump_valid <= w_read;
            // Oldest entry sits log_count slots behind the write pointer.
            if (w_start) begin
                r_rd_ptr    <= r_wr_ptr - r_count[ADDR_W-1:0];
                r_remaining <= r_count;
            end else if (w_read) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_take) begin
                if (w_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign bus.busy       = !w_idle;
    assign bus.dump_done  = (r_state == DONE);
    assign bus.dump_valid = r_dump_valid;
    assign bus.dump_data  = r_dump_valid ? bus.ram_do : '0;
    assign bus.log_count  = r_count;
    assign bus.log_full   = w_full;
    assign bus.overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_maint_log_ctrl.sv
`default_nettype none
// =====================================================================
// tb_maint_log_ctrl : WRAP=1 and WRAP=0 instances driven in lockstep
//                     against a queue-based log model.   Rev 1.0
// =====================================================================
module tb_maint_log_ctrl;

    localparam int NS    = 4;
    localparam int AW    = 11;
    localparam int DW    = 8;
    localparam int DEPTH = 2048;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req   = '0;
    logic [31:0] data  = '0;
    logic        ds    = 1'b0;
    logic [7:0]  ram_do0, ram_do1;
    logic [7:0]  mem0 [DEPTH];
    logic [7:0]  mem1 [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    maint_log_ctrl_if #(.NUM_SRC(NS), .ADDR_W(AW), .DATA_W(DW)) b0 ();
    maint_log_ctrl_if #(.NUM_SRC(NS), .ADDR_W(AW), .DATA_W(DW)) b1 ();

    assign b0.src_req = req;  assign b0.src_data = data;  assign b0.dump_start = ds;  assign b0.ram_do = ram_do0;
    assign b1.src_req = req;  assign b1.src_data = data;  assign b1.dump_start = ds;  assign b1.ram_do = ram_do1;

    maint_log_ctrl #(.NUM_SRC(NS), .ADDR_W(AW), .DATA_W(DW), .WRAP(1'b1)) u_wrap (.clk(clk), .reset(reset), .bus(b0));
    maint_log_ctrl #(.NUM_SRC(NS), .ADDR_W(AW), .DATA_W(DW), .WRAP(1'b0)) u_drop (.clk(clk), .reset(reset), .bus(b1));

    always @(posedge clk) begin
        if (b0.ram_en) begin
            if (b0.ram_we) mem0[b0.ram_addr] <= b0.ram_di;
            else           ram_do0 <= mem0[b0.ram_addr];
        end
        if (b1.ram_en) begin
            if (b1.ram_we) mem1[b1.ram_addr] <= b1.ram_di;
            else           ram_do1 <= mem1[b1.ram_addr];
        end
    end

    // Reference model: the log is a plain queue of entries, oldest first.
    logic [7:0] lq0[$], lq1[$], dq0[$], dq1[$];
    int cnt, wp0, wp1, rr, busy_left, dump_total;
    bit ovf0, ovf1;
    logic [3:0]  e_ack;
    logic        e_we0, e_we1, e_busy, e_done, e_valid, e_full, e_ovf0, e_ovf1;
    logic [10:0] e_addr0, e_addr1;
    logic [7:0]  e_di, e_data0, e_data1;
    logic [11:0] e_cnt;

    function automatic logic [49:0] outs0();
        return {b0.src_ack, b0.ram_en, b0.ram_we, b0.ram_addr, b0.ram_di, b0.dump_valid, b0.dump_data,
                b0.dump_done, b0.busy, b0.log_count, b0.log_full, b0.overflow};
    endfunction

    function automatic logic [49:0] outs1();
        return {b1.src_ack, b1.ram_en, b1.ram_we, b1.ram_addr, b1.ram_di, b1.dump_valid, b1.dump_data,
                b1.dump_done, b1.busy, b1.log_count, b1.log_full, b1.overflow};
    endfunction

    task automatic model_reset();
        lq0.delete(); lq1.delete(); dq0.delete(); dq1.delete();
        cnt = 0; wp0 = 0; wp1 = 0; rr = 0; busy_left = 0; dump_total = 0;
        ovf0 = 1'b0; ovf1 = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; data = '0; ds = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Drive one cycle's inputs, then derive this cycle's expected outputs.
    task automatic step(input logic [3:0] r, input logic [31:0] d, input logic s);
        int g;
        bit b;
        @(negedge clk);
        req = r; data = d; ds = s;
        #1;
        b       = (busy_left > 0);
        e_busy  = b;
        e_done  = b && (busy_left == 1);
        e_valid = b && (busy_left >= 2) && (busy_left <= dump_total - 1);
        e_data0 = e_valid ? dq0[dump_total - 1 - busy_left] : 8'h00;
        e_data1 = e_valid ? dq1[dump_total - 1 - busy_left] : 8'h00;
        e_cnt   = 12'(cnt);
        e_full  = (cnt == DEPTH);
        e_ovf0  = ovf0;
        e_ovf1  = ovf1;
        e_ack = '0; e_we0 = 1'b0; e_we1 = 1'b0; e_addr0 = '0; e_addr1 = '0; e_di = '0;
        if (b) begin
            busy_left--;
        end else if (s) begin
            dump_total = (cnt == 0) ? 1 : cnt + 2;
            busy_left  = dump_total;
            dq0 = lq0;
            dq1 = lq1;
        end else if (r != 4'b0) begin
            g = -1;
            for (int k = 0; k < NS; k++) if (g < 0 && r[(rr + k) % NS]) g = (rr + k) % NS;
            e_ack = 4'(1 << g);
            e_di  = d[g*8 +: 8];
            rr    = (g + 1) % NS;
            if (cnt < DEPTH) begin
                e_we0 = 1'b1; e_we1 = 1'b1; e_addr0 = 11'(wp0); e_addr1 = 11'(wp1);
                lq0.push_back(e_di); lq1.push_back(e_di);
                cnt++;
                wp0 = (wp0 + 1) % DEPTH; wp1 = (wp1 + 1) % DEPTH;
            end else begin
                e_we0 = 1'b1; e_addr0 = 11'(wp0);
                void'(lq0.pop_front());
                lq0.push_back(e_di);
                wp0 = (wp0 + 1) % DEPTH;
                ovf0 = 1'b1; ovf1 = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 4'hF; data = 32'hFFFF_FFFF; ds = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (outs0() !== '0) begin n_fail++; $display("FAIL reset_outs_wrap: got %h want 0", outs0()); end
        n_checks++;
        if (outs1() !== '0) begin n_fail++; $display("FAIL reset_outs_drop: got %h want 0", outs1()); end
        req = '0; data = '0; ds = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_write();
        do_reset();
        step(4'b0010, 32'h0000_A500, 1'b0);
        n_checks++;
        if ({b0.src_ack, b0.ram_we, b0.ram_en, b0.ram_addr, b0.ram_di} !== {4'b0010, 1'b1, 1'b1, 11'd0, 8'hA5})
        begin n_fail++; $display("FAIL single_write: got %h/%b/%0d/%h want 2/1/0/a5", b0.src_ack, b0.ram_we, b0.ram_addr, b0.ram_di); end
        step(4'b0000, 32'h0, 1'b0);
        n_checks++;
        if (b0.log_count !== 12'd1 || b1.log_count !== 12'd1)
        begin n_fail++; $display("FAIL single_count: got %0d/%0d want 1", b0.log_count, b1.log_count); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [5];
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100; exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, $urandom(), 1'b0);
            n_checks++;
            if (b0.src_ack !== exp_seq[i] || b0.ram_addr !== 11'(i) || b0.ram_di !== e_di)
            begin n_fail++; $display("FAIL rr_grant[%0d]: got ack %b addr %0d di %h want %b %0d %h", i, b0.src_ack, b0.ram_addr, b0.ram_di, exp_seq[i], i, e_di); end
        end
    endtask

    task automatic test_dump();
        logic [7:0] got[$];
        int first_v, last_v, done_c, ack_c;
        bit bad_cnt;
        do_reset();
        step(4'b0001, 32'h11, 1'b0);
        step(4'b0001, 32'h22, 1'b0);
        step(4'b0001, 32'h33, 1'b0);
        step(4'b0000, 32'h0, 1'b1);
        first_v = -1; last_v = -1; done_c = -1; ack_c = -1; bad_cnt = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step(4'b1000, 32'h7700_0000, 1'b0);
            if (b0.dump_valid) begin got.push_back(b0.dump_data); if (first_v < 0) first_v = c; last_v = c; end
            if (b0.dump_done && done_c < 0) done_c = c;
            if (b0.src_ack != 4'b0 && ack_c < 0) ack_c = c;
            if (c <= 5 && b0.log_count !== 12'd3) bad_cnt = 1'b1;
        end
        n_checks++;
        if (got.size() != 3 || first_v != 2 || last_v != 4)
        begin n_fail++; $display("FAIL dump_window: got %0d entries cycles %0d..%0d want 3 at 2..4", got.size(), first_v, last_v); end
        n_checks++;
        if (got.size() != 3 || got[0] !== 8'h11 || got[1] !== 8'h22 || got[2] !== 8'h33)
        begin n_fail++; $display("FAIL dump_data: got %p want 11 22 33", got); end
        n_checks++;
        if (done_c != 5) begin n_fail++; $display("FAIL dump_done_cycle: got %0d want 5", done_c); end
        n_checks++;
        if (ack_c != 6) begin n_fail++; $display("FAIL held_req_ack_cycle: got %0d want 6", ack_c); end
        n_checks++;
        if (bad_cnt) begin n_fail++; $display("FAIL dump_count: got changed want 3"); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 2) == 0) ? 4'b0 : 4'($urandom_range(1, 15)), $urandom(), ($urandom_range(0, 39) == 0));
            n_checks++;
            if ({b0.src_ack, b0.ram_we, b0.ram_we ? b0.ram_addr : 11'h0, b0.ram_we ? b0.ram_di : 8'h0} !==
                {e_ack, e_we0, e_addr0, e_we0 ? e_di : 8'h0})
            begin n_fail++; $display("FAIL rand_port_wrap[%0d]: got %b %b %0d %h want %b %b %0d %h", i, b0.src_ack, b0.ram_we, b0.ram_addr, b0.ram_di, e_ack, e_we0, e_addr0, e_di); end
            n_checks++;
            if ({b1.src_ack, b1.ram_we, b1.ram_we ? b1.ram_addr : 11'h0, b1.ram_we ? b1.ram_di : 8'h0} !==
                {e_ack, e_we1, e_addr1, e_we1 ? e_di : 8'h0})
            begin n_fail++; $display("FAIL rand_port_drop[%0d]: got %b %b %0d %h want %b %b %0d %h", i, b1.src_ack, b1.ram_we, b1.ram_addr, b1.ram_di, e_ack, e_we1, e_addr1, e_di); end
            n_checks++;
            if ({b0.busy, b0.dump_done, b0.dump_valid, b0.dump_data, b0.log_count, b0.log_full, b0.overflow} !==
                {e_busy, e_done, e_valid, e_data0, e_cnt, e_full, e_ovf0})
            begin n_fail++; $display("FAIL rand_status_wrap[%0d]: got %b%b%b %h %0d want %b%b%b %h %0d", i, b0.busy, b0.dump_done, b0.dump_valid, b0.dump_data, b0.log_count, e_busy, e_done, e_valid, e_data0, e_cnt); end
            n_checks++;
            if ({b1.busy, b1.dump_done, b1.dump_valid, b1.dump_data, b1.log_count, b1.log_full, b1.overflow} !==
                {e_busy, e_done, e_valid, e_data1, e_cnt, e_full, e_ovf1})
            begin n_fail++; $display("FAIL rand_status_drop[%0d]: got %b%b%b %h %0d want %b%b%b %h %0d", i, b1.busy, b1.dump_done, b1.dump_valid, b1.dump_data, b1.log_count, e_busy, e_done, e_valid, e_data1, e_cnt); end
        end
    endtask

    // Full dump of both logs, every beat checked against the queue snapshot.
    task automatic run_full_dump(output int nv0, output int nv1, output logic [7:0] f0, output logic [7:0] l0,
                                 output logic [7:0] f1, output logic [7:0] l1, output bit seen_done);
        nv0 = 0; nv1 = 0; f0 = '0; l0 = '0; f1 = '0; l1 = '0; seen_done = 1'b0;
        step(4'b0000, 32'h0, 1'b1);
        for (int c = 0; c < DEPTH + 8 && !seen_done; c++) begin
            step(4'b0000, 32'h0, 1'b0);
            n_checks++;
            if ({b0.dump_valid, b0.dump_data, b1.dump_valid, b1.dump_data} !== {e_valid, e_data0, e_valid, e_data1})
            begin n_fail++; $display("FAIL full_dump_beat[%0d]: got %b %h %b %h want %b %h %b %h", c, b0.dump_valid, b0.dump_data, b1.dump_valid, b1.dump_data, e_valid, e_data0, e_valid, e_data1); end
            if (b0.dump_valid) begin if (nv0 == 0) f0 = b0.dump_data; l0 = b0.dump_data; nv0++; end
            if (b1.dump_valid) begin if (nv1 == 0) f1 = b1.dump_data; l1 = b1.dump_data; nv1++; end
            if (b0.dump_done) seen_done = 1'b1;
        end
    endtask

    task automatic test_full_log();
        int nv0, nv1;
        logic [7:0] f0, l0, f1, l1;
        bit seen_done;
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(4'b0001, 32'(i[7:0]), 1'b0);
        step(4'b0001, 32'h0000_00EE, 1'b0);
        n_checks++;
        if ({b0.src_ack, b0.ram_we, b0.ram_addr, b0.ram_di, b0.log_count, b0.log_full, b0.overflow} !==
            {4'b0001, 1'b1, 11'd0, 8'hEE, 12'd2048, 1'b1, 1'b0})
        begin n_fail++; $display("FAIL wrap_overwrite: got %b %b %0d %h %0d %b %b", b0.src_ack, b0.ram_we, b0.ram_addr, b0.ram_di, b0.log_count, b0.log_full, b0.overflow); end
        n_checks++;
        if ({b1.src_ack, b1.ram_we, b1.ram_en} !== {4'b0001, 1'b0, 1'b0})
        begin n_fail++; $display("FAIL drop_write: got %b %b %b want 0001 0 0", b1.src_ack, b1.ram_we, b1.ram_en); end
        step(4'b0000, 32'h0, 1'b0);
        n_checks++;
        if ({b0.log_count, b0.log_full, b0.overflow, b1.log_count, b1.log_full, b1.overflow} !==
            {12'd2048, 1'b1, 1'b1, 12'd2048, 1'b1, 1'b1})
        begin n_fail++; $display("FAIL full_status: got %0d %b %b / %0d %b %b", b0.log_count, b0.log_full, b0.overflow, b1.log_count, b1.log_full, b1.overflow); end
        run_full_dump(nv0, nv1, f0, l0, f1, l1, seen_done);
        n_checks++;
        if (nv0 != DEPTH || nv1 != DEPTH || !seen_done)
        begin n_fail++; $display("FAIL full_dump_len: got %0d/%0d done %b want 2048", nv0, nv1, seen_done); end
        n_checks++;
        if ({f0, l0, f1, l1} !== {8'h01, 8'hEE, 8'h00, 8'hFF})
        begin n_fail++; $display("FAIL full_dump_ends: got %h %h %h %h want 01 ee 00 ff", f0, l0, f1, l1); end
        step(4'b0100, 32'h005A_0000, 1'b0);
        n_checks++;
        if ({b1.src_ack, b1.ram_we, b1.overflow, b1.log_count, b0.ram_we, b0.ram_addr} !==
            {4'b0100, 1'b0, 1'b1, 12'd2048, 1'b1, 11'd1})
        begin n_fail++; $display("FAIL drop_5a: got %b %b %b %0d / %b %0d", b1.src_ack, b1.ram_we, b1.overflow, b1.log_count, b0.ram_we, b0.ram_addr); end
        run_full_dump(nv0, nv1, f0, l0, f1, l1, seen_done);
        n_checks++;
        if (nv1 != DEPTH || {f0, l0, f1, l1} !== {8'h02, 8'h5A, 8'h00, 8'hFF})
        begin n_fail++; $display("FAIL redump_ends: got %0d %h %h %h %h want 2048 02 5a 00 ff", nv1, f0, l0, f1, l1); end
    endtask

    task automatic test_empty_dump();
        do_reset();
        step(4'b0000, 32'h0, 1'b1);
        step(4'b0000, 32'h0, 1'b0);
        n_checks++;
        if ({b0.dump_done, b0.dump_valid, b0.busy, b1.dump_done, b1.dump_valid} !== 5'b10110)
        begin n_fail++; $display("FAIL empty_dump: got done %b valid %b busy %b want 1 0 1", b0.dump_done, b0.dump_valid, b0.busy); end
        step(4'b0000, 32'h0, 1'b0);
        n_checks++;
        if ({b0.dump_done, b0.busy} !== 2'b00)
        begin n_fail++; $display("FAIL empty_dump_end: got done %b busy %b want 0 0", b0.dump_done, b0.busy); end
    endtask

    task automatic test_reset_mid_dump();
        bit bad;
        do_reset();
        for (int i = 0; i < 5; i++) step(4'($urandom_range(1, 15)), $urandom(), 1'b0);
        step(4'b0000, 32'h0, 1'b1);
        step(4'b0000, 32'h0, 1'b0);
        step(4'b0000, 32'h0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (outs0() !== '0 || outs1() !== '0)
        begin n_fail++; $display("FAIL mid_dump_reset: got %h / %h want 0", outs0(), outs1()); end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(4'b0000, 32'h0, 1'b0);
            if (b0.dump_done || b1.dump_done || b0.log_count !== 12'd0 || b0.busy) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin n_fail++; $display("FAIL post_reset_idle: got done/count/busy activity want none"); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_dump();
        test_random();
        test_full_log();
        test_empty_dump();
        test_reset_mid_dump();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
